// File: rtl/t16_core_pkg.sv
// Shared types for the t16q core: ALU opcodes, flag layout, execute-stage states.
package t16_core_pkg;

    localparam int DATA_W  = 16;
    localparam int SHAMT_W = 4;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_XOR = 3'd4,
        ALU_MOV = 3'd5,
        ALU_CMP = 3'd6,
        ALU_SHR = 3'd7
    } ALUOp;

    typedef struct packed {
        logic z;
        logic c;
        logic n;
        logic v;
    } Flags;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } exec_state_e;

    // Shifts never overflow; carry is the last bit pushed out.
    function automatic Flags shiftFlags(input logic [DATA_W-1:0] res, input logic carry);
        Flags f;
        f.z = (res == '0);
        f.c = carry;
        f.n = res[DATA_W-1];
        f.v = 1'b0;
        return f;
    endfunction

endpackage

// File: rtl/t16_shift_unit.sv
// SHR decode and shifter for exec_stage. Iterative 1-bit/cycle by default;
// defining T16_BARREL_SHIFT_EN swaps in a single-cycle barrel shifter.
module t16_shift_unit
    import t16_core_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               flush_i,
    input  logic               start_i,
    input  logic [DATA_W-1:0]  s1_i,
    input  logic               dirLeft_i,
    input  logic [SHAMT_W-1:0] amt_i,
    output logic               imm_o,
    output logic               done_o,
    output logic               busy_o,
    output logic [DATA_W-1:0]  res_o,
    output logic               carry_o
);

    logic [SHAMT_W-1:0] shamt;

    assign shamt = dirLeft_i ? ((~amt_i) + SHAMT_W'(1)) : amt_i;

`ifdef T16_BARREL_SHIFT_EN
    logic [DATA_W:0] leftExt;
    logic [DATA_W:0] rightExt;
    logic            unusedBarrel;

    // The extra bit beyond the data catches the last bit shifted out.
    assign leftExt  = {1'b0, s1_i} << shamt;
    assign rightExt = {s1_i, 1'b0} >> shamt;

    assign res_o   = dirLeft_i ? leftExt[DATA_W-1:0] : rightExt[DATA_W:1];
    assign carry_o = dirLeft_i ? leftExt[DATA_W] : rightExt[0];
    assign imm_o   = 1'b1;
    assign done_o  = 1'b0;
    assign busy_o  = 1'b0;

    assign unusedBarrel = &{1'b0, clk, rst, flush_i, start_i};
`else
    exec_state_e        state_q;
    logic [DATA_W-1:0]  acc_q;
    logic [SHAMT_W-1:0] cnt_q;
    logic               dirLeft_q;
    logic [DATA_W-1:0]  stepRes;
    logic               stepCarry;

    always_comb begin
        if (dirLeft_q) begin
            stepRes   = {acc_q[DATA_W-2:0], 1'b0};
            stepCarry = acc_q[DATA_W-1];
        end else begin
            stepRes   = {1'b0, acc_q[DATA_W-1:1]};
            stepCarry = acc_q[0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            cnt_q     <= '0;
            dirLeft_q <= 1'b0;
        end else if (flush_i) begin
            state_q <= IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i && (shamt != '0)) begin
                        acc_q     <= s1_i;
                        cnt_q     <= shamt;
                        dirLeft_q <= dirLeft_i;
                        state_q   <= SHIFT;
                    end
                end
                SHIFT: begin
                    acc_q <= stepRes;
                    cnt_q <= cnt_q - SHAMT_W'(1);
                    if (cnt_q == SHAMT_W'(1)) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // While shifting, res/carry describe the step taken on the coming edge;
    // when idle they describe the zero-distance case, which completes at once.
    assign busy_o  = (state_q == SHIFT);
    assign done_o  = busy_o && (cnt_q == SHAMT_W'(1));
    assign imm_o   = (shamt == '0);
    assign res_o   = busy_o ? stepRes : s1_i;
    assign carry_o = busy_o && stepCarry;
`endif

endmodule

// File: rtl/exec_stage.sv
// Execute stage of the t16q core: drives the external ALU, finishes SHR locally,
// and holds one result for writeback. T16_BARREL_SHIFT_EN selects a 1-cycle SHR.
module exec_stage
    import t16_core_pkg::*;
#(
    parameter int RD_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_op,
    input  logic [DATA_W-1:0] in_s1,
    input  logic [DATA_W-1:0] in_s2,
    input  logic [RD_W-1:0]   in_rd,
    input  logic              in_setf,
    output logic [2:0]        alu_op,
    output logic [DATA_W-1:0] alu_s1,
    output logic [DATA_W-1:0] alu_s2,
    input  logic [DATA_W-1:0] alu_d,
    input  logic [3:0]        alu_flags,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_d,
    output logic [RD_W-1:0]   out_rd,
    output logic [3:0]        flags_q,
    output logic              busy
);

    logic              outValid_q, outValid_d;
    logic [DATA_W-1:0] outD_q, outD_d;
    logic [RD_W-1:0]   outRd_q, outRd_d;
    Flags              archFlags_q, archFlags_d;
    logic [RD_W-1:0]   pendRd_q, pendRd_d;
    logic              pendSetf_q, pendSetf_d;

    logic              accept;
    logic              isShr;
    logic              shImm;
    logic              shDone;
    logic              shBusy;
    logic [DATA_W-1:0] shRes;
    logic              shCarry;

    assign alu_op = in_op;
    assign alu_s1 = in_s1;
    assign alu_s2 = in_s2;

    assign isShr    = (in_op == ALU_SHR);
    assign in_ready = !rst && !flush && !shBusy && (!outValid_q || out_ready);
    assign accept   = in_valid && in_ready;

    t16_shift_unit u_shift (
        .clk       (clk),
        .rst       (rst),
        .flush_i   (flush),
        .start_i   (accept && isShr),
        .s1_i      (in_s1),
        .dirLeft_i (in_s2[DATA_W-1]),
        .amt_i     (in_s2[SHAMT_W-1:0]),
        .imm_o     (shImm),
        .done_o    (shDone),
        .busy_o    (shBusy),
        .res_o     (shRes),
        .carry_o   (shCarry)
    );

    // A multi-cycle SHR parks rd/setf until its last shift edge; the output
    // register is empty for the whole shift, so that write needs no handshake.
    always_comb begin
        outValid_d  = outValid_q;
        outD_d      = outD_q;
        outRd_d     = outRd_q;
        archFlags_d = archFlags_q;
        pendRd_d    = pendRd_q;
        pendSetf_d  = pendSetf_q;
        if (flush) begin
            outValid_d = 1'b0;
        end else begin
            if (outValid_q && out_ready) begin
                outValid_d = 1'b0;
            end
            if (accept && (!isShr || shImm)) begin
                outValid_d = 1'b1;
                outRd_d    = in_rd;
                if (isShr) begin
                    outD_d = shRes;
                    if (in_setf) begin
                        archFlags_d = shiftFlags(shRes, shCarry);
                    end
                end else begin
                    outD_d = alu_d;
                    if (in_setf) begin
                        archFlags_d = Flags'(alu_flags);
                    end
                end
            end else if (accept) begin
                pendRd_d   = in_rd;
                pendSetf_d = in_setf;
            end
            if (shDone) begin
                outValid_d = 1'b1;
                outD_d     = shRes;
                outRd_d    = pendRd_q;
                if (pendSetf_q) begin
                    archFlags_d = shiftFlags(shRes, shCarry);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            outValid_q  <= 1'b0;
            outD_q      <= '0;
            outRd_q     <= '0;
            archFlags_q <= '0;
            pendRd_q    <= '0;
            pendSetf_q  <= 1'b0;
        end else begin
            outValid_q  <= outValid_d;
            outD_q      <= outD_d;
            outRd_q     <= outRd_d;
            archFlags_q <= archFlags_d;
            pendRd_q    <= pendRd_d;
            pendSetf_q  <= pendSetf_d;
        end
    end

    assign out_valid = outValid_q;
    assign out_d     = outD_q;
    assign out_rd    = outRd_q;
    assign flags_q   = archFlags_q;
    assign busy      = shBusy;

endmodule

// File: tb/tb_exec_stage.sv
// Self-checking bench for exec_stage: directed scenarios plus randomized ops
// checked against an arithmetic reference model of the stage.
module tb_exec_stage;
    import t16_core_pkg::*;

`ifdef T16_BARREL_SHIFT_EN
    localparam bit BARREL = 1'b1;
`else
    localparam bit BARREL = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, in_setf;
    logic [2:0]  in_op, alu_op, in_rd, out_rd;
    logic [15:0] in_s1, in_s2, alu_s1, alu_s2, alu_d, out_d;
    logic [3:0]  alu_flags, flags_q;
    logic        out_valid, out_ready, busy;

    int total = 0;
    int bad = 0;
    logic [3:0] expFlags = 4'h0;

    always #5 clk = ~clk;

    exec_stage #(.RD_W(3)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_s1(in_s1), .in_s2(in_s2), .in_rd(in_rd), .in_setf(in_setf),
        .alu_op(alu_op), .alu_s1(alu_s1), .alu_s2(alu_s2),
        .alu_d(alu_d), .alu_flags(alu_flags),
        .out_valid(out_valid), .out_ready(out_ready), .out_d(out_d), .out_rd(out_rd),
        .flags_q(flags_q), .busy(busy)
    );

    // External ALU: {z,c,n,v, result}; SHR yields 0 here.
    function automatic logic [19:0] aluModel(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        logic [16:0] w;
        logic        v;
        w = '0;
        v = 1'b0;
        case (op)
            ALU_ADD: begin w = {1'b0, a} + {1'b0, b}; v = (a[15] == b[15]) && (w[15] != a[15]); end
            ALU_SUB, ALU_CMP: begin w = {1'b0, a} - {1'b0, b}; v = (a[15] != b[15]) && (w[15] != a[15]); end
            ALU_AND: w = {1'b0, a & b};
            ALU_OR:  w = {1'b0, a | b};
            ALU_XOR: w = {1'b0, a ^ b};
            ALU_MOV: w = {1'b0, b};
            default: w = '0;
        endcase
        return {w[15:0] == 16'h0, w[16], w[15], v, w[15:0]};
    endfunction

    always_comb {alu_flags, alu_d} = aluModel(alu_op, alu_s1, alu_s2);

    function automatic void refModel(input logic [2:0] op, input logic [15:0] s1, input logic [15:0] s2,
                                     input logic setf, input logic [3:0] oldFlags,
                                     output logic [15:0] res, output logic [3:0] fl, output int lat);
        logic [19:0] a;
        int          n;
        logic        c;
        fl = oldFlags;
        if (op == ALU_SHR) begin
            n = s2[15] ? (16 - int'(s2[3:0])) % 16 : int'(s2[3:0]);
            if (n == 0) begin
                res = s1; c = 1'b0;
            end else if (s2[15]) begin
                res = 16'(32'(s1) << n); c = s1[16-n];
            end else begin
                res = s1 >> n; c = s1[n-1];
            end
            if (setf) fl = {res == 16'h0, c, res[15], 1'b0};
            lat = (BARREL || n == 0) ? 1 : n + 1;
        end else begin
            a = aluModel(op, s1, s2);
            res = a[15:0];
            if (setf) fl = a[19:16];
            lat = 1;
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idleIn();
        in_valid = 1'b0; in_op = 3'd0; in_s1 = 16'h0; in_s2 = 16'h0; in_rd = 3'd0; in_setf = 1'b0;
    endtask

    // Presents one op for one edge, then waits (bounded) for the result; lat=-1 on timeout.
    task automatic issue(input logic [2:0] op, input logic [15:0] s1, input logic [15:0] s2,
                         input logic [2:0] rd, input logic setf, output int lat, output int busyCnt);
        in_valid = 1'b1; in_op = op; in_s1 = s1; in_s2 = s2; in_rd = rd; in_setf = setf;
        tick();
        idleIn();
        lat = 1;
        busyCnt = 0;
        while (!out_valid && lat < 40) begin
            if (busy) busyCnt++;
            tick();
            lat++;
        end
        if (!out_valid) lat = -1;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; out_ready = 1'b1; idleIn();
        tick(); tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid: got %b want 0", out_valid); end
        total++; if (out_d !== 16'h0) begin bad++; $display("[TB] FAIL reset_d: got %h want 0000", out_d); end
        total++; if (out_rd !== 3'd0) begin bad++; $display("[TB] FAIL reset_rd: got %0d want 0", out_rd); end
        total++; if (flags_q !== 4'h0) begin bad++; $display("[TB] FAIL reset_flags: got %b want 0000", flags_q); end
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("[TB] FAIL reset_ready: got %b want 0", in_ready); end
        rst = 1'b0;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL post_reset_ready: got %b want 1", in_ready); end
        expFlags = 4'h0;
    endtask

    task automatic test_alu_passthrough();
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b0; in_op = 3'($urandom_range(0, 7));
            in_s1 = 16'($urandom); in_s2 = 16'($urandom);
            #1;
            total++; if (alu_op !== in_op || alu_s1 !== in_s1 || alu_s2 !== in_s2) begin
                bad++; $display("[TB] FAIL alu_pass: got %h/%h/%h want %h/%h/%h", alu_op, alu_s1, alu_s2, in_op, in_s1, in_s2);
            end
            tick();
            total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL no_valid_no_accept: got %b want 0", out_valid); end
        end
        idleIn();
    endtask

    task automatic test_add_flags();
        int lat, bc;
        issue(ALU_ADD, 16'h7FFF, 16'h0001, 3'd5, 1'b1, lat, bc);
        total++; if (lat !== 1) begin bad++; $display("[TB] FAIL add_lat: got %0d want 1", lat); end
        total++; if (out_d !== 16'h8000) begin bad++; $display("[TB] FAIL add_d: got %h want 8000", out_d); end
        total++; if (out_rd !== 3'd5) begin bad++; $display("[TB] FAIL add_rd: got %0d want 5", out_rd); end
        total++; if (flags_q !== 4'b0011) begin bad++; $display("[TB] FAIL add_flags: got %b want 0011", flags_q); end
        expFlags = 4'b0011;
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL add_drain: got %b want 0", out_valid); end
    endtask

    task automatic test_shr_basic();
        int lat, bc;
        issue(ALU_SHR, 16'h8001, 16'h0004, 3'd2, 1'b1, lat, bc);
        total++; if (bc !== (BARREL ? 0 : 4)) begin bad++; $display("[TB] FAIL shr4_busy: got %0d want %0d", bc, BARREL ? 0 : 4); end
        total++; if (lat !== (BARREL ? 1 : 5)) begin bad++; $display("[TB] FAIL shr4_lat: got %0d want %0d", lat, BARREL ? 1 : 5); end
        total++; if (out_d !== 16'h0800) begin bad++; $display("[TB] FAIL shr4_d: got %h want 0800", out_d); end
        total++; if (out_rd !== 3'd2) begin bad++; $display("[TB] FAIL shr4_rd: got %0d want 2", out_rd); end
        total++; if (flags_q !== 4'b0000) begin bad++; $display("[TB] FAIL shr4_flags: got %b want 0000", flags_q); end
        issue(ALU_SHR, 16'h8001, 16'h800F, 3'd4, 1'b1, lat, bc);
        total++; if (bc !== (BARREL ? 0 : 1)) begin bad++; $display("[TB] FAIL shl1_busy: got %0d want %0d", bc, BARREL ? 0 : 1); end
        total++; if (out_d !== 16'h0002) begin bad++; $display("[TB] FAIL shl1_d: got %h want 0002", out_d); end
        total++; if (flags_q !== 4'b0100) begin bad++; $display("[TB] FAIL shl1_flags: got %b want 0100", flags_q); end
        expFlags = 4'b0100;
        tick();
    endtask

    task automatic test_backpressure();
        int lat, bc;
        out_ready = 1'b0;
        issue(ALU_ADD, 16'h0001, 16'h0002, 3'd3, 1'b0, lat, bc);
        in_valid = 1'b1; in_op = ALU_MOV; in_s2 = 16'hBEEF; in_rd = 3'd6;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++; if (in_ready !== 1'b0) begin bad++; $display("[TB] FAIL bp_ready%0d: got %b want 0", i, in_ready); end
            tick();
            total++; if (out_valid !== 1'b1 || out_d !== 16'h0003 || out_rd !== 3'd3) begin
                bad++; $display("[TB] FAIL bp_hold%0d: got %b/%h/%0d want 1/0003/3", i, out_valid, out_d, out_rd);
            end
        end
        out_ready = 1'b1;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL bp_release_ready: got %b want 1", in_ready); end
        tick();
        idleIn();
        total++; if (out_valid !== 1'b1 || out_d !== 16'hBEEF || out_rd !== 3'd6) begin
            bad++; $display("[TB] FAIL bp_swap: got %b/%h/%0d want 1/beef/6", out_valid, out_d, out_rd);
        end
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL bp_drain: got %b want 0", out_valid); end
        total++; if (flags_q !== expFlags) begin bad++; $display("[TB] FAIL bp_flags: got %b want %b", flags_q, expFlags); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] a, b;
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            a = 16'($urandom); b = 16'($urandom);
            in_valid = 1'b1; in_op = ALU_ADD; in_s1 = a; in_s2 = b; in_rd = 3'(i); in_setf = 1'b0;
            tick();
            total++; if (out_valid !== 1'b1 || out_d !== 16'(a + b) || out_rd !== 3'(i)) begin
                bad++; $display("[TB] FAIL b2b%0d: got %b/%h/%0d want 1/%h/%0d", i, out_valid, out_d, out_rd, 16'(a + b), i);
            end
        end
        idleIn();
        tick();
    endtask

    task automatic test_flush_shift();
        int rises;
        in_valid = 1'b1; in_op = ALU_SHR; in_s1 = 16'h1234; in_s2 = 16'h0008; in_rd = 3'd1; in_setf = 1'b1;
        tick();
        idleIn();
        tick(); tick();
        flush = 1'b1;
        #1;
        total++; if (in_ready !== 1'b0) begin bad++; $display("[TB] FAIL flush_ready_low: got %b want 0", in_ready); end
        tick();
        flush = 1'b0;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL flush_ready: got %b want 1", in_ready); end
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL flush_busy: got %b want 0", busy); end
        total++; if (flags_q !== expFlags) begin bad++; $display("[TB] FAIL flush_flags: got %b want %b", flags_q, expFlags); end
        rises = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (out_valid) rises++;
        end
        total++; if (rises !== 0) begin bad++; $display("[TB] FAIL flush_no_valid: got %0d want 0", rises); end
    endtask

    task automatic test_reset_mid_shift();
        int lat, bc;
        in_valid = 1'b1; in_op = ALU_SHR; in_s1 = 16'hFFFF; in_s2 = 16'h000A; in_rd = 3'd7; in_setf = 1'b1;
        tick();
        idleIn();
        tick(); tick();
        rst = 1'b1;
        tick();
        total++; if (out_valid !== 1'b0 || out_d !== 16'h0 || out_rd !== 3'd0) begin
            bad++; $display("[TB] FAIL rst_mid_out: got %b/%h/%0d want 0/0000/0", out_valid, out_d, out_rd);
        end
        total++; if (flags_q !== 4'h0 || busy !== 1'b0) begin bad++; $display("[TB] FAIL rst_mid_state: got %b/%b want 0000/0", flags_q, busy); end
        rst = 1'b0;
        expFlags = 4'h0;
        issue(ALU_ADD, 16'h1111, 16'h2222, 3'd1, 1'b1, lat, bc);
        total++; if (lat !== 1 || out_d !== 16'h3333 || out_rd !== 3'd1) begin
            bad++; $display("[TB] FAIL rst_then_add: got %0d/%h/%0d want 1/3333/1", lat, out_d, out_rd);
        end
        tick();
    endtask

    task automatic test_shr_zero();
        int lat, bc;
        issue(ALU_SHR, 16'hA5A5, 16'h0000, 3'd3, 1'b1, lat, bc);
        total++; if (lat !== 1 || out_d !== 16'hA5A5) begin bad++; $display("[TB] FAIL shr0_pos: got %0d/%h want 1/a5a5", lat, out_d); end
        total++; if (flags_q !== 4'b0010) begin bad++; $display("[TB] FAIL shr0_pos_flags: got %b want 0010", flags_q); end
        tick();
        issue(ALU_SHR, 16'hA5A5, 16'h8000, 3'd4, 1'b1, lat, bc);
        total++; if (lat !== 1 || out_d !== 16'hA5A5 || out_rd !== 3'd4) begin
            bad++; $display("[TB] FAIL shr0_neg: got %0d/%h/%0d want 1/a5a5/4", lat, out_d, out_rd);
        end
        total++; if (flags_q !== 4'b0010) begin bad++; $display("[TB] FAIL shr0_neg_flags: got %b want 0010", flags_q); end
        expFlags = 4'b0010;
        tick();
    endtask

    task automatic test_random();
        logic [2:0]  op, rd;
        logic [15:0] s1, s2, res;
        logic [3:0]  fl;
        logic        setf;
        int          lat, bc, expLat;
        out_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            op = ($urandom_range(0, 2) == 0) ? ALU_SHR : 3'($urandom_range(0, 6));
            s1 = 16'($urandom); s2 = 16'($urandom); rd = 3'($urandom); setf = 1'($urandom);
            refModel(op, s1, s2, setf, expFlags, res, fl, expLat);
            issue(op, s1, s2, rd, setf, lat, bc);
            total++; if (lat !== expLat || bc !== expLat - 1) begin
                bad++; $display("[TB] FAIL rnd%0d_lat: got %0d/%0d want %0d/%0d", i, lat, bc, expLat, expLat - 1);
            end
            total++; if (out_d !== res || out_rd !== rd) begin
                bad++; $display("[TB] FAIL rnd%0d_out: op %0d got %h/%0d want %h/%0d", i, op, out_d, out_rd, res, rd);
            end
            total++; if (flags_q !== fl) begin bad++; $display("[TB] FAIL rnd%0d_flags: got %b want %b", i, flags_q, fl); end
            expFlags = fl;
            if ($urandom_range(0, 1) == 1) tick();
        end
    endtask

    initial begin
        test_reset();
        test_alu_passthrough();
        test_add_flags();
        test_shr_basic();
        test_backpressure();
        test_back_to_back();
        test_flush_shift();
        test_reset_mid_shift();
        test_shr_zero();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
